// File: rtl/icache_nway.sv
// icache_nway: N-way set-associative read-only instruction cache with burst refill and round-robin replacement.
// Define ICACHE_PERF_EN to add hit_cnt/miss_cnt performance counter outputs.
module icache_nway #(
  parameter int WAYS       = 4,
  parameter int SET_BITS   = 6,
  parameter int LINE_WORDS = 8
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req,
  input  logic [31:0] addr,
  output logic        ready,
  output logic        ok,
  output logic [31:0] ins,
  input  logic        inv,
  output logic        sen,
  output logic [31:0] saddr,
  input  logic        addr_ok,
  input  logic        data_ok,
  input  logic [31:0] sdata
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
`endif
);
  localparam int SETS     = 1 << SET_BITS;
  localparam int OFF_BITS = $clog2(LINE_WORDS);
  localparam int TAG_BITS = 30 - SET_BITS - OFF_BITS;
  localparam int WB       = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam logic [2:0] IDLE = 3'd0, LOOKUP = 3'd1, REQ = 3'd2, FILL = 3'd3, RESP = 3'd4;

  logic [2:0] state_q, state_d;
  logic [29:0] addr_q, addr_d;
  logic inv_pend_q, inv_pend_d, ok_q, ok_d, vrr_q, vrr_d;
  logic [31:0] ins_q, ins_d, crit_q, crit_d;
  logic [WB-1:0] victim_q, victim_d, hit_way, vic;
  logic [OFF_BITS-1:0] beat_q, beat_d;
  logic [SETS-1:0] valid_q [WAYS];
  logic [SETS-1:0] valid_d [WAYS];
  logic [WB-1:0] ptr_q [SETS];
  logic [WB-1:0] ptr_d [SETS];
  logic [TAG_BITS-1:0] tag_q [WAYS][SETS];
  logic [31:0] data_q [WAYS][SETS][LINE_WORDS];
  logic hit, any_inv, fill_we, fill_last, clr, unused;
  logic [TAG_BITS-1:0] tag;
  logic [SET_BITS-1:0] idx;
  logic [OFF_BITS-1:0] wrd;

  assign unused = ^addr[1:0];
  assign tag    = addr_q[29:SET_BITS+OFF_BITS];
  assign idx    = addr_q[SET_BITS+OFF_BITS-1:OFF_BITS];
  assign wrd    = addr_q[OFF_BITS-1:0];
  assign ready  = rstn & (state_q == IDLE) & ~inv & ~inv_pend_q;
  assign sen    = (state_q == REQ);
  assign saddr  = {addr_q[29:OFF_BITS], {(OFF_BITS+2){1'b0}}};
  assign ok     = ok_q;
  assign ins    = ins_q;
  assign clr    = (state_q == IDLE) & (inv | inv_pend_q);
  assign fill_we   = (state_q == FILL) & data_ok;
  assign fill_last = fill_we & (beat_q == OFF_BITS'(LINE_WORDS - 1));

  // Descending scans so the lowest-numbered matching / invalid way wins.
  always_comb begin
    hit = 1'b0;
    hit_way = '0;
    any_inv = 1'b0;
    vic = ptr_q[idx];
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[w][idx] && tag_q[w][idx] == tag) begin
        hit = 1'b1;
        hit_way = WB'(w);
      end
      if (!valid_q[w][idx]) begin
        any_inv = 1'b1;
        vic = WB'(w);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    inv_pend_d = inv_pend_q | (inv & (state_q != IDLE));
    ok_d = 1'b0;
    ins_d = ins_q;
    crit_d = crit_q;
    victim_d = victim_q;
    vrr_d = vrr_q;
    beat_d = beat_q;
    case (state_q)
      IDLE: begin
        if (clr) inv_pend_d = 1'b0;
        else if (req) begin
          addr_d = addr[31:2];
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        if (hit) begin
          ok_d = 1'b1;
          ins_d = data_q[hit_way][idx][wrd];
          state_d = IDLE;
        end else begin
          victim_d = vic;
          vrr_d = ~any_inv;
          state_d = REQ;
        end
      end
      REQ: begin
        if (addr_ok) begin
          beat_d = '0;
          state_d = FILL;
        end
      end
      FILL: begin
        if (data_ok) begin
          crit_d = (beat_q == wrd) ? sdata : crit_q;
          beat_d = beat_q + 1'b1;
          state_d = fill_last ? RESP : FILL;
        end
      end
      RESP: begin
        ok_d = 1'b1;
        ins_d = crit_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    for (int w = 0; w < WAYS; w++) valid_d[w] = clr ? '0 : valid_q[w];
    if (fill_last) valid_d[victim_q][idx] = 1'b1;
    ptr_d = ptr_q;
    if (fill_last && vrr_q && WAYS > 1) ptr_d[idx] = ptr_q[idx] + 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      addr_q <= '0;
      inv_pend_q <= 1'b0;
      ok_q <= 1'b0;
      ins_q <= '0;
      crit_q <= '0;
      victim_q <= '0;
      vrr_q <= 1'b0;
      beat_q <= '0;
      for (int w = 0; w < WAYS; w++) valid_q[w] <= '0;
      for (int s = 0; s < SETS; s++) ptr_q[s] <= '0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      inv_pend_q <= inv_pend_d;
      ok_q <= ok_d;
      ins_q <= ins_d;
      crit_q <= crit_d;
      victim_q <= victim_d;
      vrr_q <= vrr_d;
      beat_q <= beat_d;
      valid_q <= valid_d;
      ptr_q <= ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_we) data_q[victim_q][idx][beat_q] <= sdata;
    if (fill_last) tag_q[victim_q][idx] <= tag;
  end

`ifdef ICACHE_PERF_EN
  logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;
  always_comb begin
    hit_cnt_d = inv ? '0 : hit_cnt_q + {31'd0, (state_q == LOOKUP) & hit};
    miss_cnt_d = inv ? '0 : miss_cnt_q + {31'd0, (state_q == LOOKUP) & ~hit};
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hit_cnt_q <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end
  assign hit_cnt = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif
endmodule

// File: tb/tb_icache_nway.sv
// tb_icache_nway: directed bench for icache_nway at default parameters (4 ways, 64 sets, 8-word lines).
module tb_icache_nway;
  logic clk = 1'b0;
  logic rstn, req, inv, addr_ok, data_ok;
  logic [31:0] addr, sdata;
  logic ready, ok, sen;
  logic [31:0] ins, saddr;
  int vectors = 0;
  int miscompares = 0;
`ifdef ICACHE_PERF_EN
  logic [31:0] hit_cnt, miss_cnt;
`endif

  icache_nway dut (
    .clk(clk), .rstn(rstn), .req(req), .addr(addr), .ready(ready), .ok(ok), .ins(ins),
    .inv(inv), .sen(sen), .saddr(saddr), .addr_ok(addr_ok), .data_ok(data_ok), .sdata(sdata)
`ifdef ICACHE_PERF_EN
    , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One fetch from IDLE; on a miss plays the bus side with beats base+i, optionally pulsing inv on beat inv_beat.
  task automatic access(input logic [31:0] a, input bit miss, input logic [31:0] base,
                        input logic [31:0] exp, input int inv_beat);
    chk("ready_idle", ready, 1);
    req = 1'b1;
    addr = a;
    @(negedge clk);
    req = 1'b0;
    chk("ok_lookup", ok, 0);
    chk("sen_lookup", sen, 0);
    @(negedge clk);
    if (!miss) begin
      chk("hit_ok", ok, 1);
      chk("hit_ins", ins, exp);
      chk("hit_sen", sen, 0);
    end else begin
      chk("miss_ok", ok, 0);
      chk("miss_sen", sen, 1);
      chk("saddr", saddr, a & 32'hFFFF_FFE0);
      data_ok = 1'b1;
      sdata = 32'hDEAD_BEEF;
      @(negedge clk);
      data_ok = 1'b0;
      chk("sen_held", sen, 1);
      @(negedge clk);
      addr_ok = 1'b1;
      @(negedge clk);
      addr_ok = 1'b0;
      for (int i = 0; i < 8; i++) begin
        data_ok = 1'b1;
        sdata = base + 32'(i);
        inv = (i == inv_beat);
        @(negedge clk);
        data_ok = 1'b0;
        inv = 1'b0;
        @(negedge clk);
      end
      chk("miss_ok_resp", ok, 1);
      chk("miss_ins", ins, exp);
      chk("miss_sen_done", sen, 0);
    end
  endtask

  initial begin
    rstn = 1'b0; req = 1'b0; inv = 1'b0; addr_ok = 1'b0; data_ok = 1'b0;
    addr = '0; sdata = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_ready", ready, 0);
    chk("rst_ok", ok, 0);
    chk("rst_ins", ins, 0);
    chk("rst_sen", sen, 0);
    chk("rst_saddr", saddr, 0);
    rstn = 1'b1;
    @(negedge clk);
    access(32'h0000_1014, 1, 32'h100, 32'h105, -1);
    access(32'h0000_101C, 0, 0, 32'h107, -1);
    // index 0x01 fills: A..D occupy ways 0..3
    access(32'h0000_0820, 1, 32'hA00, 32'hA00, -1);
    access(32'h0000_1020, 1, 32'hB00, 32'hB00, -1);
    access(32'h0000_1820, 1, 32'hC00, 32'hC00, -1);
    access(32'h0000_2020, 1, 32'hD00, 32'hD00, -1);
    access(32'h0000_0824, 0, 0, 32'hA01, -1);
    access(32'h0000_2820, 1, 32'hE00, 32'hE00, -1);
    access(32'h0000_1024, 0, 0, 32'hB01, -1);
    access(32'h0000_3020, 1, 32'hF00, 32'hF00, -1);
    access(32'h0000_1828, 0, 0, 32'hC02, -1);
    access(32'h0000_0820, 1, 32'hA80, 32'hA80, -1);
    access(32'h0000_2024, 0, 0, 32'hD01, -1);
    access(32'h0000_282C, 0, 0, 32'hE03, -1);
    access(32'h0000_3030, 0, 0, 32'hF04, -1);
    access(32'h0000_1820, 1, 32'hC80, 32'hC80, -1);
    access(32'h0000_2020, 1, 32'hD80, 32'hD80, -1);
    access(32'h0000_3030, 0, 0, 32'hF04, -1);
    access(32'h0000_083C, 0, 0, 32'hA87, -1);
    // invalidate during refill
    access(32'h0000_4040, 1, 32'h400, 32'h400, 3);
    chk("inv_pend_ready", ready, 0);
    @(negedge clk);
    chk("inv_done_ready", ready, 1);
    access(32'h0000_4040, 1, 32'h410, 32'h410, -1);
    access(32'h0000_101C, 1, 32'h200, 32'h207, -1);
    // inv and req together in IDLE
    req = 1'b1;
    addr = 32'h0000_4044;
    inv = 1'b1;
    #1;
    chk("inv_req_ready", ready, 0);
    @(negedge clk);
    inv = 1'b0;
    #1;
    chk("inv_req_sen", sen, 0);
    access(32'h0000_4044, 1, 32'h420, 32'h421, -1);
    // reset during REQ
    req = 1'b1;
    addr = 32'h0000_5000;
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    chk("rreq_sen", sen, 1);
    #2;
    rstn = 1'b0;
    #1;
    chk("rreq_sen_rst", sen, 0);
    chk("rreq_ok_rst", ok, 0);
    chk("rreq_ready_rst", ready, 0);
    chk("rreq_saddr_rst", saddr, 0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    access(32'h0000_1018, 1, 32'h300, 32'h306, -1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/icache_nway.md
Name: icache_nway

Overview:
- Parametrised successor to the team's fixed 4-way, 16-word-line instruction cache.
- Read-only, N-way set-associative instruction cache between the fetch stage and the SRAM-like bus bridge.
- Tag, valid and data arrays are internal registers; no vendor RAM IP is used.
- Adds over the previous generation: way count and line size as parameters, a real burst refill handshake, critical-word capture, whole-cache invalidate, and per-set round-robin replacement.

Parameters:
- WAYS, 4, number of ways; power of two, 1..8 (1 = direct-mapped).
- SET_BITS, 6, index width; 2**SET_BITS sets.
- LINE_WORDS, 8, 32-bit words per line; power of two, 2..16.
- Derived widths: OFF_BITS = log2(LINE_WORDS); TAG_BITS = 30 - SET_BITS - OFF_BITS.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- req  in  1  fetch request
- addr  in  32  fetch byte address; bits [1:0] ignored
- ready  out  1  cache accepts req this cycle
- ok  out  1  one-cycle pulse; ins valid
- ins  out  32  fetched instruction
- inv  in  1  invalidate all lines (pulse)
- sen  out  1  bus read request
- saddr  out  32  line-aligned bus address
- addr_ok  in  1  bus accepted sen/saddr
- data_ok  in  1  one refill beat valid on sdata
- sdata  in  32  refill beat

Behaviour:
- Reset (rstn low, asynchronous):
  - state IDLE; all valid bits 0; all round-robin pointers 0; inv_pend 0.
  - ok=0, ins=0, sen=0, saddr=0, ready=0 while rstn low.
- Address split: tag = addr[31:32-TAG_BITS], index = addr[OFF_BITS+SET_BITS+1:OFF_BITS+2], word = addr[OFF_BITS+1:2].
- ready = (state==IDLE) & ~inv & ~inv_pend.
- A request is accepted when req & ready. addr is latched; req is ignored in all other cycles.
- States:
  - IDLE: on accept -> LOOKUP. If inv or inv_pend: clear all valid bits, clear inv_pend, stay in IDLE.
  - LOOKUP: compare the latched tag against all ways of the latched index.
    - Hit (valid & equal, lowest way wins if several match): ok=1, ins=word from the hit way -> IDLE. Hit latency is 2 cycles from accept.
    - Miss: choose the victim = lowest-numbered invalid way, else the set's round-robin pointer -> REQ.
  - REQ: sen=1, saddr={tag,index,OFF_BITS+2 zero bits}, held until addr_ok. data_ok is ignored in this state. On addr_ok -> FILL, beat counter = 0.
  - FILL: on each data_ok, write sdata into victim word[beat]. If beat == latched word, capture it into the critical-word register. Increment beat.
    - On the beat with index LINE_WORDS-1: write tag, set valid. If the victim was the pointer choice, advance that set's pointer by 1 modulo WAYS -> RESP.
  - RESP: ok=1, ins=critical-word register -> IDLE. Miss latency = 3 + bus cycles.
- Beats arrive in order, word 0 first. There is no wrap-first ordering.
- ins holds its value between ok pulses. Only ok qualifies ins.
- Invalidate:
  - inv in IDLE takes priority over a simultaneous req; that req is not accepted that cycle.
  - inv outside IDLE sets inv_pend. The current operation completes normally, including the refill tag/valid write. Invalidation is applied on the first IDLE cycle.
- After ok, if req is still high in IDLE it is a new request.
- Reset mid-refill aborts immediately. The bus bridge shares rstn, so no stray data_ok is delivered afterwards.
- WAYS=1: no pointer state; victim is always way 0.
- The requester must not assume ready in LOOKUP, REQ, FILL or RESP.

Optional Feature:
- Macro: ICACHE_PERF_EN.
- When defined, adds two outputs:
  - hit_cnt[31:0]: increments on each LOOKUP hit.
  - miss_cnt[31:0]: increments on each LOOKUP miss.
- Both counters wrap at 2**32, reset to 0, and are also cleared by inv.
- When not defined, neither the ports nor the counters exist; behaviour is otherwise identical.

Test Plan:
- Cold miss, defaults:
  - Stimulus: req addr=0x0000_1014; bus returns addr_ok 2 cycles after sen, beats 0x100+i with one idle cycle between beats.
  - Required: saddr=0x0000_1000; ok with ins=0x105.
- Hit after fill: req 0x0000_101C -> ok exactly 2 cycles after accept, ins=0x107, sen stays 0.
- Replacement (WAYS=4, same index 0x01):
  - Stimulus: fill tags A,B,C,D, then miss on E.
  - Required: E evicts way 0 and the pointer becomes 1. A next miss on F evicts way 1. A re-request of A misses.
- Invalidate during FILL:
  - Stimulus: pulse inv at beat 3.
  - Required: refill completes with ok. ready stays 0 for one extra IDLE cycle. The same address then misses again.
- Simultaneous inv and req in IDLE: req is not accepted that cycle; the req held on the following cycle is accepted and misses.
- Reset mid-REQ: drop rstn while sen=1 -> sen=0 and ok=0 asynchronously. After release, the previously filled address misses.
